// File: rtl/mps_system_fsm.sv
// mps_system_fsm
// Magnet power supply sequencer. Turns register-driven command levels into
// the contactor power-on / power-off sequences, drives the contactors and
// PWM enable, and reports state codes back to the register block.
//
// Ports
//   i_clk               system clock
//   i_rst_n             asynchronous active-low reset
//   i_op_on .. i_intl_clr  command levels, rising edge is the command
//   i_intl              aggregated interlock, active high level
//   i_mc_fb[2:0]        contactor aux feedback, 1 = closed
//   o_mc[2:0]           contactor drive: [0] precharge, [1] main, [2] output
//   o_pwm_en            PWM enable
//   o_mps_fsm_m[2:0]    main state code
//   o_op_on_fsm[3:0]    on-sequence sub-state code
//   o_op_off_fsm[3:0]   off-sequence sub-state code
//   o_on_state_fail_buf[3:0]  latched failing step code (8+n for off steps)
//
// Main states
//   state   | meaning
//   IDLE    | all contactors open, waiting for op_on
//   OP_ON   | running the contactor close sequence (see on sub-states)
//   READY   | contactors closed, PWM off
//   RUN     | contactors closed, PWM on
//   OP_OFF  | running the contactor open sequence (see off sub-states)
//   FAULT   | everything open, waiting for intl_clr with interlock low
module mps_system_fsm #(
  parameter int P_PRECHARGE_CNT = 100_000_000,
  parameter int P_MC_CNT        = 10_000_000,
  parameter int P_PWM_OFF_CNT   = 1_000_000,
  parameter int P_CNT_W         = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_op_on,
  input  logic       i_run,
  input  logic       i_ready,
  input  logic       i_op_off,
  input  logic       i_intl_clr,
  input  logic       i_intl,
  input  logic [2:0] i_mc_fb,
  output logic [2:0] o_mc,
  output logic       o_pwm_en,
  output logic [2:0] o_mps_fsm_m,
  output logic [3:0] o_op_on_fsm,
  output logic [3:0] o_op_off_fsm,
  output logic [3:0] o_on_state_fail_buf
);

  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_OP_ON  = 3'd1,
    M_READY  = 3'd2,
    M_RUN    = 3'd3,
    M_OP_OFF = 3'd4,
    M_FAULT  = 3'd5
  } main_t;

  typedef enum logic [3:0] {
    ON_NONE      = 4'd0,
    ON_PRE_CLOSE = 4'd1,
    ON_PRE_WAIT  = 4'd2,
    ON_MAIN_CLOSE = 4'd3,
    ON_PRE_OPEN  = 4'd4,
    ON_OUT_CLOSE = 4'd5,
    ON_DONE      = 4'd6
  } on_t;

  typedef enum logic [3:0] {
    OFF_NONE     = 4'd0,
    OFF_PWM_OFF  = 4'd1,
    OFF_OUT_OPEN = 4'd2,
    OFF_ALL_OPEN = 4'd3,
    OFF_DONE     = 4'd4
  } off_t;

  localparam logic [P_CNT_W-1:0] MC_LAST  = P_CNT_W'(P_MC_CNT - 1);
  localparam logic [P_CNT_W-1:0] PRE_LAST = P_CNT_W'(P_PRECHARGE_CNT - 1);
  localparam logic [P_CNT_W-1:0] PWM_LAST = P_CNT_W'(P_PWM_OFF_CNT - 1);
  localparam logic [P_CNT_W-1:0] TMR_MAX  = {P_CNT_W{1'b1}};

  main_t              main_q, main_d;
  on_t                on_q, on_d;
  off_t               off_q, off_d;
  logic [2:0]         mc_q, mc_d;
  logic               pwm_q, pwm_d;
  logic [3:0]         fail_q, fail_d;
  logic [P_CNT_W-1:0] timer_q, timer_d;
  logic [4:0]         prev_q;
  logic [4:0]         lvl;
  logic [4:0]         cmd_edge;
  logic               to_fault;
  logic               step_chg;

  // bit order: 0 op_on, 1 op_off, 2 run, 3 ready, 4 intl_clr
  assign lvl      = {i_intl_clr, i_ready, i_run, i_op_off, i_op_on};
  assign cmd_edge = lvl & ~prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q  <= M_IDLE;
      on_q    <= ON_NONE;
      off_q   <= OFF_NONE;
      mc_q    <= 3'b000;
      pwm_q   <= 1'b0;
      fail_q  <= 4'd0;
      timer_q <= '0;
      prev_q  <= 5'b0;
    end else begin
      main_q  <= main_d;
      on_q    <= on_d;
      off_q   <= off_d;
      mc_q    <= mc_d;
      pwm_q   <= pwm_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      prev_q  <= lvl;
    end
  end

  always_comb begin
    main_d   = main_q;
    on_d     = on_q;
    off_d    = off_q;
    mc_d     = mc_q;
    pwm_d    = pwm_q;
    fail_d   = fail_q;
    to_fault = 1'b0;

    case (main_q)
      M_IDLE: begin
        mc_d  = 3'b000;
        pwm_d = 1'b0;
        if (cmd_edge[0] && !i_intl) begin
          main_d = M_OP_ON;
          on_d   = ON_PRE_CLOSE;
          mc_d   = 3'b001;
        end
      end

      M_OP_ON: begin
        if (i_intl) begin
          to_fault = 1'b1;
        end else if (cmd_edge[1]) begin
          // abort: contactors stay as they are until the off sequence opens them
          main_d = M_OP_OFF;
          on_d   = ON_NONE;
          off_d  = OFF_PWM_OFF;
          pwm_d  = 1'b0;
        end else begin
          case (on_q)
            ON_PRE_CLOSE: begin
              if (timer_q == MC_LAST) begin
                if (i_mc_fb[0]) begin
                  on_d = ON_PRE_WAIT;
                end else begin
                  fail_d   = 4'd1;
                  to_fault = 1'b1;
                end
              end
            end
            ON_PRE_WAIT: begin
              if (timer_q == PRE_LAST) begin
                on_d = ON_MAIN_CLOSE;
                mc_d = 3'b011;
              end
            end
            ON_MAIN_CLOSE: begin
              if (timer_q == MC_LAST) begin
                if (i_mc_fb[1:0] == 2'b11) begin
                  on_d = ON_PRE_OPEN;
                  mc_d = 3'b010;
                end else begin
                  fail_d   = 4'd3;
                  to_fault = 1'b1;
                end
              end
            end
            ON_PRE_OPEN: begin
              if (timer_q == MC_LAST) begin
                if (i_mc_fb == 3'b010) begin
                  on_d = ON_OUT_CLOSE;
                  mc_d = 3'b110;
                end else begin
                  fail_d   = 4'd4;
                  to_fault = 1'b1;
                end
              end
            end
            ON_OUT_CLOSE: begin
              if (timer_q == MC_LAST) begin
                if (i_mc_fb == 3'b110) begin
                  on_d = ON_DONE;
                end else begin
                  fail_d   = 4'd5;
                  to_fault = 1'b1;
                end
              end
            end
            ON_DONE: begin
              main_d = M_READY;
              on_d   = ON_NONE;
            end
            default: to_fault = 1'b1;
          endcase
        end
      end

      M_READY: begin
        if (i_intl) begin
          to_fault = 1'b1;
        end else if (cmd_edge[1]) begin
          main_d = M_OP_OFF;
          off_d  = OFF_PWM_OFF;
          pwm_d  = 1'b0;
        end else if (cmd_edge[2]) begin
          main_d = M_RUN;
          pwm_d  = 1'b1;
        end
      end

      M_RUN: begin
        if (i_intl) begin
          to_fault = 1'b1;
        end else if (cmd_edge[1]) begin
          main_d = M_OP_OFF;
          off_d  = OFF_PWM_OFF;
          pwm_d  = 1'b0;
        end else if (cmd_edge[3]) begin
          main_d = M_READY;
          pwm_d  = 1'b0;
        end
      end

      M_OP_OFF: begin
        if (i_intl) begin
          to_fault = 1'b1;
        end else begin
          case (off_q)
            OFF_PWM_OFF: begin
              pwm_d = 1'b0;
              if (timer_q == PWM_LAST) begin
                off_d = OFF_OUT_OPEN;
                mc_d  = mc_q & 3'b011;
              end
            end
            OFF_OUT_OPEN: begin
              if (timer_q == MC_LAST) begin
                off_d = OFF_ALL_OPEN;
                mc_d  = 3'b000;
              end
            end
            OFF_ALL_OPEN: begin
              if (timer_q == MC_LAST) begin
                if (i_mc_fb == 3'b000) begin
                  off_d = OFF_DONE;
                end else begin
                  fail_d   = 4'hB;
                  to_fault = 1'b1;
                end
              end
            end
            OFF_DONE: begin
              main_d = M_IDLE;
              off_d  = OFF_NONE;
            end
            default: to_fault = 1'b1;
          endcase
        end
      end

      M_FAULT: begin
        mc_d  = 3'b000;
        pwm_d = 1'b0;
        on_d  = ON_NONE;
        off_d = OFF_NONE;
        if (cmd_edge[4] && !i_intl) begin
          main_d = M_IDLE;
          fail_d = 4'd0;
        end
      end

      default: to_fault = 1'b1;
    endcase

    if (to_fault) begin
      main_d = M_FAULT;
      on_d   = ON_NONE;
      off_d  = OFF_NONE;
      mc_d   = 3'b000;
      pwm_d  = 1'b0;
    end
  end

  // timer restarts on any state or sub-state change, otherwise saturates
  assign step_chg = (main_d != main_q) || (on_d != on_q) || (off_d != off_q);

  always_comb begin
    if (step_chg) begin
      timer_d = '0;
    end else if (timer_q == TMR_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign o_mc                = mc_q;
  assign o_pwm_en            = pwm_q;
  assign o_mps_fsm_m         = main_q;
  assign o_op_on_fsm         = on_q;
  assign o_op_off_fsm        = off_q;
  assign o_on_state_fail_buf = fail_q;

endmodule

// File: tb/tb_mps_system_fsm.sv
// Directed bench for mps_system_fsm with short timer parameters.
// Contactor feedback follows o_mc two clocks late, optionally masked (stuck
// open) or OR-ed (stuck closed).
module tb_mps_system_fsm;

  logic       clk;
  logic       rst_n;
  logic       op_on, run, ready, op_off, intl_clr, intl;
  logic [2:0] mc_fb;
  logic [2:0] mc;
  logic       pwm_en;
  logic [2:0] fsm_m;
  logic [3:0] on_fsm, off_fsm, fail_buf;

  logic [2:0] fb_d1, fb_d2, fb_mask, fb_or;

  int checks   = 0;
  int failures = 0;

  mps_system_fsm #(
    .P_PRECHARGE_CNT(20),
    .P_MC_CNT(5),
    .P_PWM_OFF_CNT(3),
    .P_CNT_W(32)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_op_on(op_on),
    .i_run(run),
    .i_ready(ready),
    .i_op_off(op_off),
    .i_intl_clr(intl_clr),
    .i_intl(intl),
    .i_mc_fb(mc_fb),
    .o_mc(mc),
    .o_pwm_en(pwm_en),
    .o_mps_fsm_m(fsm_m),
    .o_op_on_fsm(on_fsm),
    .o_op_off_fsm(off_fsm),
    .o_on_state_fail_buf(fail_buf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_d1 <= 3'b000;
      fb_d2 <= 3'b000;
    end else begin
      fb_d1 <= mc;
      fb_d2 <= fb_d1;
    end
  end
  assign mc_fb = (fb_d2 & fb_mask) | fb_or;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // op_on edge, then wait out the full on sequence (4*5 + 20 + 1 = 41 cycles)
  task automatic do_on(input string tag);
    op_on = 1'b1;
    tick();
    op_on = 1'b0;
    step(41);
    chk(tag, 8'(fsm_m), 8'h02);
  endtask

  initial begin
    rst_n = 1'b0;
    op_on = 0; run = 0; ready = 0; op_off = 0; intl_clr = 0; intl = 0;
    fb_mask = 3'b111;
    fb_or   = 3'b000;
    #3;
    chk("rst_main", 8'(fsm_m), 8'h00);
    chk("rst_mc", 8'(mc), 8'h00);
    chk("rst_pwm", 8'(pwm_en), 8'h00);
    chk("rst_buf", 8'(fail_buf), 8'h00);
    #9 rst_n = 1'b1;
    tick();

    // nominal on sequence: edge k
    op_on = 1'b1;
    tick();
    op_on = 1'b0;
    chk("on_k_main", 8'(fsm_m), 8'h01);
    chk("on_k_sub", 8'(on_fsm), 8'h01);
    chk("on_k_mc", 8'(mc), 8'h01);
    step(4);
    chk("on_k4_sub", 8'(on_fsm), 8'h01);
    step(1);
    chk("on_k5_sub", 8'(on_fsm), 8'h02);
    step(19);
    chk("on_k24_sub", 8'(on_fsm), 8'h02);
    step(1);
    chk("on_k25_sub", 8'(on_fsm), 8'h03);
    chk("on_k25_mc", 8'(mc), 8'h03);
    step(5);
    chk("on_k30_sub", 8'(on_fsm), 8'h04);
    chk("on_k30_mc", 8'(mc), 8'h02);
    step(5);
    chk("on_k35_sub", 8'(on_fsm), 8'h05);
    chk("on_k35_mc", 8'(mc), 8'h06);
    step(5);
    chk("on_k40_sub", 8'(on_fsm), 8'h06);
    chk("on_k40_main", 8'(fsm_m), 8'h01);
    step(1);
    chk("on_k41_main", 8'(fsm_m), 8'h02);
    chk("on_k41_mc", 8'(mc), 8'h06);
    chk("on_k41_sub", 8'(on_fsm), 8'h00);

    // run / ready toggle
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_main", 8'(fsm_m), 8'h03);
    chk("run_pwm", 8'(pwm_en), 8'h01);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ready_main", 8'(fsm_m), 8'h02);
    chk("ready_pwm", 8'(pwm_en), 8'h00);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run2_pwm", 8'(pwm_en), 8'h01);

    // off sequence from RUN: edge k
    op_off = 1'b1;
    tick();
    op_off = 1'b0;
    chk("off_k_main", 8'(fsm_m), 8'h04);
    chk("off_k_sub", 8'(off_fsm), 8'h01);
    chk("off_k_pwm", 8'(pwm_en), 8'h00);
    chk("off_k_mc", 8'(mc), 8'h06);
    step(3);
    chk("off_k3_mc", 8'(mc), 8'h02);
    chk("off_k3_sub", 8'(off_fsm), 8'h02);
    step(5);
    chk("off_k8_mc", 8'(mc), 8'h00);
    chk("off_k8_sub", 8'(off_fsm), 8'h03);
    step(5);
    chk("off_k13_sub", 8'(off_fsm), 8'h04);
    step(1);
    chk("off_k14_main", 8'(fsm_m), 8'h00);
    chk("off_k14_sub", 8'(off_fsm), 8'h00);

    // interlock in IDLE blocks op_on without faulting
    intl  = 1'b1;
    op_on = 1'b1;
    tick();
    chk("idle_intl_main", 8'(fsm_m), 8'h00);
    op_on = 1'b0;
    intl  = 1'b0;
    tick();

    // stuck main contactor
    fb_mask = 3'b101;
    op_on = 1'b1;
    tick();
    op_on = 1'b0;
    step(29);
    chk("stuck_k29_sub", 8'(on_fsm), 8'h03);
    step(1);
    chk("stuck_main", 8'(fsm_m), 8'h05);
    chk("stuck_buf", 8'(fail_buf), 8'h03);
    chk("stuck_mc", 8'(mc), 8'h00);
    chk("stuck_sub", 8'(on_fsm), 8'h00);
    fb_mask = 3'b111;
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
    chk("stuck_clr_main", 8'(fsm_m), 8'h00);
    chk("stuck_clr_buf", 8'(fail_buf), 8'h00);

    // stuck main with interlock on the check edge: interlock wins, buf unchanged
    fb_mask = 3'b101;
    op_on = 1'b1;
    tick();
    op_on = 1'b0;
    step(29);
    intl = 1'b1;
    tick();
    chk("intl_chk_main", 8'(fsm_m), 8'h05);
    chk("intl_chk_buf", 8'(fail_buf), 8'h00);
    fb_mask = 3'b111;
    intl = 1'b0;
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
    chk("intl_chk_clr", 8'(fsm_m), 8'h00);
    step(3);

    // interlock in RUN
    do_on("intl_run_ready");
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("intl_run_main", 8'(fsm_m), 8'h03);
    intl = 1'b1;
    tick();
    chk("intl_fault_main", 8'(fsm_m), 8'h05);
    chk("intl_fault_pwm", 8'(pwm_en), 8'h00);
    chk("intl_fault_mc", 8'(mc), 8'h00);
    chk("intl_fault_buf", 8'(fail_buf), 8'h00);
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
    chk("intl_clr_blocked", 8'(fsm_m), 8'h05);
    tick();
    intl = 1'b0;
    tick();
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
    chk("intl_clr_ok", 8'(fsm_m), 8'h00);
    step(3);

    // abort at k+10 during PRECHG_WAIT
    op_on = 1'b1;
    tick();
    op_on = 1'b0;
    step(9);
    op_off = 1'b1;
    tick();
    op_off = 1'b0;
    chk("abort_main", 8'(fsm_m), 8'h04);
    chk("abort_off_sub", 8'(off_fsm), 8'h01);
    chk("abort_on_sub", 8'(on_fsm), 8'h00);
    chk("abort_mc", 8'(mc), 8'h01);
    step(14);
    chk("abort_idle", 8'(fsm_m), 8'h00);

    // simultaneous op_off and run edges in READY
    step(3);
    do_on("prio_ready");
    op_off = 1'b1;
    run    = 1'b1;
    tick();
    op_off = 1'b0;
    run    = 1'b0;
    chk("prio_main", 8'(fsm_m), 8'h04);
    chk("prio_pwm", 8'(pwm_en), 8'h00);
    step(14);
    chk("prio_idle", 8'(fsm_m), 8'h00);

    // op_on held high through the whole cycle issues one command only
    step(3);
    op_on = 1'b1;
    tick();
    step(41);
    chk("hold_ready", 8'(fsm_m), 8'h02);
    op_off = 1'b1;
    tick();
    op_off = 1'b0;
    step(14);
    chk("hold_idle", 8'(fsm_m), 8'h00);
    step(5);
    chk("hold_no_restart", 8'(fsm_m), 8'h00);
    chk("hold_no_sub", 8'(on_fsm), 8'h00);
    op_on = 1'b0;
    step(3);

    // precharge stuck closed during off: off-sequence fail code
    do_on("offfail_ready");
    fb_or = 3'b001;
    op_off = 1'b1;
    tick();
    op_off = 1'b0;
    step(12);
    chk("offfail_k12_sub", 8'(off_fsm), 8'h03);
    step(1);
    chk("offfail_main", 8'(fsm_m), 8'h05);
    chk("offfail_buf", 8'(fail_buf), 8'h0B);
    fb_or = 3'b000;
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
    chk("offfail_clr_buf", 8'(fail_buf), 8'h00);
    step(3);

    // reset in the middle of PRECHG_WAIT
    op_on = 1'b1;
    tick();
    op_on = 1'b0;
    step(10);
    chk("mid_sub", 8'(on_fsm), 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_main", 8'(fsm_m), 8'h00);
    chk("mid_rst_mc", 8'(mc), 8'h00);
    chk("mid_rst_sub", 8'(on_fsm), 8'h00);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("mid_idle", 8'(fsm_m), 8'h00);
    do_on("mid_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
